// File: rtl/ahb_lite_fir_slave_gen.sv
// ahb_lite_fir_slave_gen: AHB-Lite slave for the FIR filter: coefficient bank, sample FIFO, two-cycle ERROR responses.
// Define FIFO_OVF_STICKY_EN to add a sticky overflow flag (status bit2, write-1-to-clear) and the ovf_irq output.
module ahb_lite_fir_slave_gen #(
  parameter int NUM_COEFF = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0] htrans,
  input  logic [2:0] hsize,
  input  logic hwrite,
  input  logic hready,
  input  logic [15:0] hwdata,
  output logic [15:0] hrdata,
  output logic hreadyout,
  output logic hresp,
  input  logic modwait,
  input  logic err,
  input  logic [15:0] fir_out,
  input  logic [((NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1)-1:0] coefficient_num,
  input  logic clear_new_coeff,
  input  logic sample_ack,
  output logic [15:0] sample_data,
  output logic data_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic new_coefficient_set,
  output logic [15:0] fir_coefficient
`ifdef FIFO_OVF_STICKY_EN
  , output logic ovf_irq
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = ADDR_W - 1;
`ifdef FIFO_OVF_STICKY_EN
  localparam logic STAT_WR = 1'b1;
`else
  localparam logic STAT_WR = 1'b0;
`endif
  logic [15:0] hrdata_q, hrdata_d, result_q, result_d, rd_coef;
  logic hreadyout_q, hreadyout_d, hresp_q, hresp_d, ncs_q, ncs_d;
  logic wr_q, wr_d, dp_half_q, dp_half_d, dp_a0_q, dp_a0_d;
  logic [HW-1:0] dp_hw_q, dp_hw_d, a_hw;
  logic [15:0] coeff_q [NUM_COEFF];
  logic [15:0] coeff_d [NUM_COEFF];
  logic [15:0] mem_q [FIFO_DEPTH];
  logic [15:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic acc, a_stat, a_res, a_smp, a_cnt, a_conf, a_coef, a_full, a_err;
  logic push, pop, dp_lo, full_now, ovf_q, unused_ok;
  assign unused_ok = htrans[0];
  assign hrdata = hrdata_q;
  assign hreadyout = hreadyout_q;
  assign hresp = hresp_q;
  assign sample_data = mem_q[rp_q];
  assign data_ready = count_q != '0;
  assign fifo_count = count_q;
  assign new_coefficient_set = ncs_q;
  assign fir_coefficient = (int'(coefficient_num) < NUM_COEFF) ? coeff_q[coefficient_num] : 16'h0;
  always_comb begin
    a_hw = haddr[ADDR_W-1:1];
    acc = hsel & htrans[1] & hready & hreadyout_q;
    a_stat = a_hw == HW'(0);
    a_res = a_hw == HW'(1);
    a_smp = a_hw == HW'(2);
    a_cnt = a_hw == HW'(3);
    a_conf = a_hw == HW'(4);
    a_coef = (a_hw >= HW'(8)) && (a_hw < HW'(8 + NUM_COEFF));
    dp_lo = dp_half_q | ~dp_a0_q;
    push = wr_q & (dp_hw_q == HW'(2));
    pop = sample_ack & data_ready;
    full_now = count_q == CW'(FIFO_DEPTH);
    // A push still in its data phase already counts toward full; a same-cycle pop does not help.
    a_full = full_now | (push & (count_q == CW'(FIFO_DEPTH - 1)));
    a_err = (hsize[2:1] != 2'b00) | ~(a_stat | a_res | a_smp | a_cnt | a_conf | a_coef)
          | (hwrite & ((a_stat & ~STAT_WR) | a_res | a_cnt | (a_smp & (~hsize[0] | a_full))));
    coeff_d = coeff_q;
    rd_coef = 16'h0;
    for (int k = 0; k < NUM_COEFF; k++) begin
      if (wr_q && dp_hw_q == HW'(8 + k)) begin
        if (dp_half_q) coeff_d[k] = hwdata;
        else if (dp_a0_q) coeff_d[k][15:8] = hwdata[15:8];
        else coeff_d[k][7:0] = hwdata[7:0];
      end
      if (a_hw == HW'(8 + k)) rd_coef = coeff_d[k];
    end
    ncs_d = clear_new_coeff ? 1'b0 : ((wr_q & (dp_hw_q == HW'(4)) & dp_lo & hwdata[0]) | ncs_q);
    mem_d = mem_q;
    if (push) mem_d[wp_q] = hwdata;
    wp_d = wp_q + PW'(push);
    rp_d = rp_q + PW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
    result_d = fir_out;
    // Read data comes from next-state values so a write in its data phase forwards to this read.
    hrdata_d = ~(acc & ~hwrite & ~a_err) ? 16'h0
             : a_stat ? {7'b0, err, 5'b0, ovf_q, full_now, modwait | ncs_q}
             : a_res  ? result_q
             : a_smp  ? sample_data
             : a_cnt  ? 16'(count_q)
             : a_conf ? {15'b0, ncs_d}
             : rd_coef;
    hresp_d = (acc & a_err) | (hresp_q & ~hreadyout_q);
    hreadyout_d = ~(acc & a_err);
    wr_d = acc & hwrite & ~a_err;
    dp_hw_d = a_hw;
    dp_half_d = hsize[0];
    dp_a0_d = haddr[0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hrdata_q <= '0;
      result_q <= '0;
      hreadyout_q <= 1'b1;
      hresp_q <= 1'b0;
      ncs_q <= 1'b0;
      wr_q <= 1'b0;
      dp_half_q <= 1'b0;
      dp_a0_q <= 1'b0;
      dp_hw_q <= '0;
      coeff_q <= '{default: '0};
      mem_q <= '{default: '0};
      wp_q <= '0;
      rp_q <= '0;
      count_q <= '0;
    end else begin
      hrdata_q <= hrdata_d;
      result_q <= result_d;
      hreadyout_q <= hreadyout_d;
      hresp_q <= hresp_d;
      ncs_q <= ncs_d;
      wr_q <= wr_d;
      dp_half_q <= dp_half_d;
      dp_a0_q <= dp_a0_d;
      dp_hw_q <= dp_hw_d;
      coeff_q <= coeff_d;
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      count_q <= count_d;
    end
  end
`ifdef FIFO_OVF_STICKY_EN
  logic ovf_d;
  assign ovf_d = (acc & hwrite & a_smp & a_full)
               | (ovf_q & ~(wr_q & (dp_hw_q == HW'(0)) & dp_lo & hwdata[2]));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  end
  assign ovf_irq = ovf_q;
`else
  assign ovf_q = 1'b0;
`endif
endmodule

// File: doc/ahb_lite_fir_slave_gen.md
Name: ahb_lite_fir_slave_gen

Overview:
- Parametrised next-generation AHB-Lite slave front end for the FIR filter datapath.
- Generalises coefficient count and address width.
- Buffers incoming samples in a FIFO instead of a single register, with a pop handshake to the filter controller.
- Issues spec-compliant two-cycle ERROR responses with wait-state control (hreadyout).

Parameters:
NUM_COEFF, 4, number of 16-bit FIR coefficients (1..8)
FIFO_DEPTH, 4, sample FIFO entries (power of two, 2..16)
ADDR_W, 6, width of haddr

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous reset, active-high
hsel  input  1  slave select
haddr  input  ADDR_W  byte address
htrans  input  2  transfer type; transfer valid when htrans[1]=1
hsize  input  3  0=byte, 1=halfword, others illegal
hwrite  input  1  1=write
hready  input  1  bus ready (address phase accepted when 1)
hwdata  input  16  write data (data phase)
hrdata  output  16  read data (data phase)
hreadyout  output  1  slave ready
hresp  output  1  1=ERROR
modwait  input  1  filter busy
err  input  1  filter error
fir_out  input  16  filter result
coefficient_num  input  $clog2(NUM_COEFF) (min 1)  coefficient select
clear_new_coeff  input  1  coefficient load done
sample_ack  input  1  pop FIFO head
sample_data  output  16  FIFO head
data_ready  output  1  FIFO non-empty
fifo_count  output  $clog2(FIFO_DEPTH)+1  occupancy
new_coefficient_set  output  1  coefficient load request
fir_coefficient  output  16  coefficient[coefficient_num]

Behaviour:
- Reset (rst=1, asynchronous):
  - all registers, FIFO pointers and count = 0
  - hrdata=0, hreadyout=1, hresp=0, data_ready=0, new_coefficient_set=0
- Address map (halfword aligned):
  - 0x00 status, RO: bit0 = modwait|new_coefficient_set, bit1 = FIFO full, bit8 = err
  - 0x02 result, RO: fir_out registered once per cycle
  - 0x04 sample, WO: push into FIFO; reads return FIFO head
  - 0x06 fifo_count, RO
  - 0x08 confirm, RW: bit0 only
  - 0x10+2k coefficient k, RW, for k < NUM_COEFF
- Address phase accepted when hsel & htrans[1] & hready. Accepted addr, size and write are registered; the data phase is the next cycle.
- Writes, coefficient registers: applied at the end of the data phase. hsize=0 writes one byte lane; addr[0] selects hwdata[15:8] vs [7:0].
- Writes, sample register: halfword only. Pushes hwdata at the end of the data phase.
- Reads: hrdata is registered from the address-phase decode and valid in the data phase.
- RAW forwarding: if a write data phase targets the same halfword as the immediately following read, hrdata returns the merged write value. This is zero extra latency.
- ERROR response (write not performed, no FIFO push). Triggered by any of:
  - unmapped address
  - write to RO
  - byte write to 0x04
  - hsize>1
  - sample write while FIFO full (full judged before any same-cycle pop)
- ERROR cycle 1: hresp=1, hreadyout=0. ERROR cycle 2: hresp=1, hreadyout=1. Any new address phase is accepted only in cycle 2.
- FIFO push and pop:
  - Pop on sample_ack & data_ready; sample_ack while empty is ignored.
  - Simultaneous push+pop when neither full nor empty: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Confirm register:
  - A write with bit0=1 sets new_coefficient_set.
  - clear_new_coeff clears it and takes priority over a same-cycle write.
- fir_coefficient is combinational from the coefficient array.
- Out-of-range coefficient_num returns 0.
- Reset mid-transfer aborts the transfer; a pending ERROR is dropped and hreadyout returns to 1.

Optional Feature:
FIFO_OVF_STICKY_EN
- Defined: adds status bit2, a sticky overflow flag set whenever a sample push is rejected for full. Writing 1 to status bit2 clears it, as the only writable status bit; such a write is not an error. Also adds an output port ovf_irq equal to the flag.
- Undefined: status bit2 reads 0, ovf_irq port absent, and any status write errors.

Test Plan:
- Reset: assert rst mid-write to 0x10 -> all outputs at reset values, coefficient 0 reads 0x0000.
- Halfword write 0x1234 to 0x12, then byte write 0xAB to 0x13 -> read 0x12 returns 0xAB34; coefficient_num=1 gives fir_coefficient=0xAB34.
- Back-to-back write 0x5A5A to 0x10, then read 0x10 -> hrdata=0x5A5A in the read data phase (RAW forward).
- Push 0x0001..0x0004 with FIFO_DEPTH=4, then a fifth push 0x0005 -> two-cycle ERROR, fifo_count stays 4, sample_data=0x0001. Pop with sample_ack -> sample_data=0x0002, count=3.
- Write 0x0001 to 0x08 while clear_new_coeff=1 -> new_coefficient_set stays 0. Write alone -> set, and status bit0=1 until clear.
- Read 0x3E (unmapped) -> hresp=1 for two cycles, hreadyout 0 then 1. Following read of 0x02 with fir_out=0x0F0F -> 0x0F0F.
